// File: rtl/pll_init_sweep_pkg.sv
// Shared types and helpers for the PLL bring-up sweep controller.
package pll_init_pkg;

    localparam int ICPSEL_W = 6;
    localparam int LPFRES_W = 3;

    // Controller states; the encoding is exported on state_o for debug.
    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_NEXT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    // Converts a duration in microseconds into init_clk cycles.
    function automatic int to_cycles(input int us, input int period_ns);
        return (us * 1000) / period_ns;
    endfunction

endpackage

// File: rtl/pll_init_sweep_if.sv
// PLL-facing signal bundle: the controller drives reset and tuning settings
// and receives the (already synchronised) lock indication.
interface pll_init_sweep_if import pll_init_pkg::*; ;

    logic                pll_lock;
    logic                pll_rst;
    logic [ICPSEL_W-1:0] icpsel;
    logic [LPFRES_W-1:0] lpfres;

    modport master (input pll_lock, output pll_rst, output icpsel, output lpfres);
    modport slave  (output pll_lock, input pll_rst, input icpsel, input lpfres);

endinterface

// File: rtl/pll_init_sweep_lock_filter.sv
// Run-length filter on the raw PLL lock: counts consecutive high cycles
// (stable) and consecutive low cycles (glitch). The owner clears it whenever
// its state changes so each phase starts counting from zero.
module lock_filter #(
    parameter int STABLE_CYCLES = 64,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_lock,
    output logic o_stable_hit,
    output logic o_glitch_hit
);

    localparam int STABLE_W = $clog2(STABLE_CYCLES) + 1;
    localparam int GLITCH_W = $clog2(GLITCH_CYCLES) + 1;
    localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(STABLE_CYCLES);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX  = GLITCH_W'(GLITCH_CYCLES);
    localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);

    logic [STABLE_W-1:0] r_stable_cnt;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    // Run-length counters, saturating at their thresholds so they never wrap.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_cnt <= '0;
            r_glitch_cnt <= '0;
        end else if (i_clear) begin
            r_stable_cnt <= '0;
            r_glitch_cnt <= '0;
        end else if (i_lock) begin
            if (r_stable_cnt != STABLE_MAX) r_stable_cnt <= r_stable_cnt + STABLE_W'(1);
            r_glitch_cnt <= '0;
        end else begin
            r_stable_cnt <= '0;
            if (r_glitch_cnt != GLITCH_MAX) r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    // Stable lock is judged on the registered count, so the lock decision
    // lands one cycle after the count is reached.
    assign o_stable_hit = (r_stable_cnt == STABLE_MAX);

    // Lock loss looks ahead at the current low sample so the drop of o_lock
    // happens in the same update in which the glitch run reaches its length.
    assign o_glitch_hit = !i_lock && (r_glitch_cnt >= GLITCH_LAST);

endmodule

// File: rtl/pll_init_sweep.sv
// PLL bring-up controller: sweeps charge-pump / loop-filter settings until a
// debounced lock is seen, relocks on the same settings after lock loss, and
// flags a sticky failure once the retry budget of full sweeps is used up.
module pll_init_sweep import pll_init_pkg::*; #(
    parameter int                  CLK_PERIOD_NS   = 20,
    parameter int                  RST_CYCLES      = 16,
    parameter int                  LOCK_TIMEOUT_US = 200,
    parameter int                  STABLE_CYCLES   = 64,
    parameter int                  GLITCH_CYCLES   = 4,
    parameter logic [ICPSEL_W-1:0] ICP_MIN         = 6'd8,
    parameter logic [ICPSEL_W-1:0] ICP_MAX         = 6'd40,
    parameter logic [LPFRES_W-1:0] LPF_MIN         = 3'd0,
    parameter logic [LPFRES_W-1:0] LPF_MAX         = 3'd7,
    parameter int                  MAX_PASSES      = 2
) (
    input  logic                   init_clk,
    input  logic                   reset_n,
    input  logic                   restart,
    pll_init_sweep_if.master       pll,
    output logic                   o_lock,
    output logic                   o_fail,
    output logic [2:0]             state_o,
    output logic [7:0]             lock_loss_cnt
);

    localparam int TO_CYC  = to_cycles(LOCK_TIMEOUT_US, CLK_PERIOD_NS);
    localparam int CNT_MAX = (TO_CYC > RST_CYCLES) ? TO_CYC : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int PASS_W  = $clog2(MAX_PASSES) + 1;

    localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TO_CYC);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [PASS_W-1:0] PASS_LIMIT = PASS_W'(MAX_PASSES);

    state_e              r_state;
    state_e              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [PASS_W-1:0]   r_pass;
    logic [PASS_W-1:0]   w_pass_inc;
    logic [ICPSEL_W-1:0] r_icp;
    logic [ICPSEL_W-1:0] w_icp_adv;
    logic [LPFRES_W-1:0] r_lpf;
    logic [LPFRES_W-1:0] w_lpf_adv;
    logic                w_wrap;
    logic                w_enter;
    logic                w_stable_hit;
    logic                w_glitch_hit;
    logic                r_pll_rst;
    logic                r_lock;
    logic                r_fail;
    logic [7:0]          r_loss_cnt;

    // Any state change (or a restart, which may re-enter the same state)
    // starts the new phase with fresh counters.
    assign w_enter = restart || (w_next != r_state);

    lock_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_lock_filter (
        .clk          (init_clk),
        .rst_n        (reset_n),
        .i_clear      (w_enter),
        .i_lock       (pll.pll_lock),
        .o_stable_hit (w_stable_hit),
        .o_glitch_hit (w_glitch_hit)
    );

    // Next candidate in sweep order: icpsel fastest, then lpfres, then wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_icp_adv  = r_icp + ICPSEL_W'(1);
        w_lpf_adv  = r_lpf;
        w_wrap     = 1'b0;
        w_pass_inc = r_pass + PASS_W'(1);
        if (r_icp == ICP_MAX) begin
            w_icp_adv = ICP_MIN;
            if (r_lpf == LPF_MAX) begin
                w_lpf_adv = LPF_MIN;
                w_wrap    = 1'b1;
            end else begin
                w_lpf_adv = r_lpf + LPFRES_W'(1);
            end
        end
    end

    // Next-state logic; restart overrides every other transition and lock
    // wins over a coincident timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST: begin
                if (r_cnt >= RST_LAST) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_stable_hit)        w_next = ST_LOCKED;
                else if (r_cnt >= TO_LAST) w_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (w_wrap && (w_pass_inc >= PASS_LIMIT)) w_next = ST_FAIL;
                else                                      w_next = ST_RST;
            end
            ST_LOCKED: begin
                if (w_glitch_hit) w_next = ST_RST;
            end
            ST_FAIL: begin
                w_next = ST_FAIL;
            end
            default: begin
                w_next = ST_RST;
            end
        endcase
        if (restart) w_next = ST_RST;
    end

    // State register plus the shared reset-length / timeout cycle counter.
    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_enter)             r_cnt <= '0;
            else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Candidate settings and pass count; settings only move on entry to RST
    // from NEXT, so they hold for a whole attempt and survive a relock.
    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_icp  <= ICP_MIN;
            r_lpf  <= LPF_MIN;
            r_pass <= '0;
        end else if (restart) begin
            r_icp  <= ICP_MIN;
            r_lpf  <= LPF_MIN;
            r_pass <= '0;
        end else if (r_state == ST_NEXT) begin
            if (w_next == ST_RST) begin
                r_icp <= w_icp_adv;
                r_lpf <= w_lpf_adv;
            end
            if (w_wrap) r_pass <= w_pass_inc;
        end else if ((w_next == ST_LOCKED) && (r_state != ST_LOCKED)) begin
            r_pass <= '0;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pll_rst <= 1'b1;
            r_lock    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_pll_rst <= (w_next == ST_RST) || (w_next == ST_FAIL);
            r_lock    <= (w_next == ST_LOCKED);
            r_fail    <= (w_next == ST_FAIL);
        end
    end

    // Saturating lock-loss counter; only a restart-free loss in LOCKED counts,
    // and restart leaves the history intact.
    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if (!restart && (r_state == ST_LOCKED) && w_glitch_hit
                     && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign pll.pll_rst    = r_pll_rst;
    assign pll.icpsel     = r_icp;
    assign pll.lpfres     = r_lpf;
    assign o_lock         = r_lock;
    assign o_fail         = r_fail;
    assign state_o        = r_state;
    assign lock_loss_cnt  = r_loss_cnt;

endmodule

// File: doc/pll_init_sweep.md
Name: pll_init_sweep

Overview:
- Parametrised PLL bring-up controller for the Tang PLL wrappers. Runs in the `init_clk` domain and drives the PLL `reset`, `icpsel` and `lpfres` inputs.
- Successor to the fixed-setting init primitive. It sweeps charge-pump and loop-filter settings until a stable lock is found.
- Adds lock debouncing, automatic relock after lock loss, a retry budget, a sticky failure flag and a lock-loss counter.

Parameters:
- CLK_PERIOD_NS, 20, `init_clk` period in ns; used to convert the µs timeout into cycles.
- RST_CYCLES, 16, cycles `pll_rst` is held high per attempt (≥1).
- LOCK_TIMEOUT_US, 200, max wait for stable lock per attempt; TO_CYC = LOCK_TIMEOUT_US*1000/CLK_PERIOD_NS.
- STABLE_CYCLES, 64, consecutive `pll_lock`=1 cycles required before declaring lock (≥1).
- GLITCH_CYCLES, 4, consecutive `pll_lock`=0 cycles in LOCKED that count as lock loss (≥1).
- ICP_MIN, 6'd8; ICP_MAX, 6'd40, inclusive `icpsel` sweep range (ICP_MIN ≤ ICP_MAX).
- LPF_MIN, 3'd0; LPF_MAX, 3'd7, inclusive `lpfres` sweep range.
- MAX_PASSES, 2, full sweeps attempted before FAIL (≥1).

Ports:
- init_clk, in, 1, controller clock.
- reset_n, in, 1, asynchronous active-low reset.
- restart, in, 1, synchronous pulse: abort the current activity and restart from the first candidate; also clears FAIL.
- pll_lock, in, 1, raw PLL lock (already in the `init_clk` domain via 2-FF sync outside).
- pll_rst, out, 1, PLL reset, active high.
- icpsel, out, 6, charge-pump setting to the PLL.
- lpfres, out, 3, loop-filter resistor setting to the PLL.
- o_lock, out, 1, qualified lock.
- o_fail, out, 1, sticky: all passes exhausted.
- state_o, out, 3, current FSM state encoding (debug).
- lock_loss_cnt, out, 8, saturating count of lock losses since reset.

Behaviour:
- Reset (async, `reset_n`=0):
  - state=RST; `pll_rst`=1; `icpsel`=ICP_MIN; `lpfres`=LPF_MIN; `o_lock`=0; `o_fail`=0; `lock_loss_cnt`=0.
  - All counters cleared.
- Candidate order:
  - `icpsel` varies fastest, ICP_MIN..ICP_MAX; then `lpfres` increments, LPF_MIN..LPF_MAX.
  - Total candidates N=(ICP_MAX-ICP_MIN+1)*(LPF_MAX-LPF_MIN+1).
  - After the last candidate, both fields wrap to their MIN values and the pass counter increments.
- `icpsel`/`lpfres` change only while in RST, and only on the cycle the state is entered, so they are stable for the whole attempt.
- FSM states:
  - RST(0): `pll_rst`=1 for exactly RST_CYCLES cycles, then WAIT. The cycle count starts at state entry.
  - WAIT(1):
    - `pll_rst`=0; the timeout counter increments every cycle; the stable counter increments while `pll_lock`=1 and clears to 0 when `pll_lock`=0.
    - Stable counter reaches STABLE_CYCLES → LOCKED; `o_lock`=1 on the next cycle.
    - Else timeout counter reaches TO_CYC → NEXT.
    - If both happen in the same cycle, lock wins.
  - NEXT(2): single cycle; advances the candidate.
    - If that wraps and the pass count reaches MAX_PASSES → FAIL.
    - Otherwise → RST.
  - LOCKED(3):
    - `o_lock`=1; the glitch counter counts consecutive `pll_lock`=0 cycles.
    - On reaching GLITCH_CYCLES: `o_lock`=0 in that same registered update, `lock_loss_cnt`+1 (saturating at 255), → RST with the SAME candidate (no advance).
    - The pass counter is reset to 0 on entry to LOCKED.
  - FAIL(4): `pll_rst`=1, `o_lock`=0, `o_fail`=1. Stays here until `restart` or reset.
- `restart`:
  - From any state, on the next edge: → RST, first candidate, pass=0, `o_fail`=0, `o_lock`=0.
  - `lock_loss_cnt` is preserved.
  - `restart` has priority over all other transitions.
- `o_lock` is registered, and is 1 only in LOCKED.
- `pll_rst` is 1 in RST and FAIL, and 0 otherwise.
- Counter widths: $clog2 of the maximum value + 1. No overflow is permitted within the legal parameter ranges.

Decomposition:
- Package `pll_init_pkg`:
  - state enum (RST, WAIT, NEXT, LOCKED, FAIL);
  - ICPSEL_W=6, LPFRES_W=3;
  - function `to_cycles(us, period_ns)`.
- One natural sub-module: `lock_filter`. It holds the stable/glitch run-length counters and outputs `stable_hit` and `glitch_hit`; the FSM clears it on state change.

Test Plan (RST_CYCLES=4, TO_CYC=50, STABLE=8, GLITCH=3, ICP 8..9, LPF 0..1, MAX_PASSES=2):
- `pll_lock` tied 1 after release → `pll_rst` high 4 cycles; `o_lock` rises 9 cycles after `pll_rst` falls; `icpsel`=8, `lpfres`=0.
- Lock only accepted when `icpsel`=9,`lpfres`=1 → three timeouts, each followed by a 4-cycle reset; `o_lock`=1 with settings 9/1.
- `pll_lock` never asserts → 4 candidates × 2 passes, then `o_fail`=1, `state_o`=4, `pll_rst`=1. `restart` pulse → `o_fail`=0, settings 8/0.
- Locked, then `pll_lock` low for 2 cycles → `o_lock` stays 1. Low for 3 cycles → `o_lock`=0, `lock_loss_cnt`=1, same settings reapplied, relock occurs.
- Stable count 7 then a 1-cycle dropout → stable counter restarts; lock is declared only after 8 fresh consecutive highs. Lock and timeout coinciding → LOCKED.
- `reset_n` asserted mid-WAIT → all outputs return to their reset values immediately (asynchronously); 300 forced losses → `lock_loss_cnt` saturates at 255.
